// File: rtl/shift_pkg.sv
// rtl/shift_pkg.sv - shared bit-order constants and default word width
package shift_pkg;

  typedef enum logic {
    LSB_FIRST = 1'b0,
    MSB_FIRST = 1'b1
  } bit_order_e;

  localparam int DEFAULT_WIDTH = 8;

endpackage

// File: rtl/mod_counter.sv
// rtl/mod_counter.sv - modulo-MOD up counter with synchronous clear and wrap strobe
module mod_counter #(
  parameter int MOD = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   inc,
  input  logic                   clr,
  output logic [$clog2(MOD)-1:0] count,
  output logic                   wrap
);

  localparam int CW = $clog2(MOD);

  logic [CW-1:0] count_q, count_d;

  // wrap marks the increment that takes the counter from MOD-1 back to 0
  assign wrap  = inc && (count_q == CW'(MOD - 1));
  assign count = count_q;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (inc) begin
      count_d = wrap ? '0 : count_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/sipo_deser.sv
// rtl/sipo_deser.sv - serial-in parallel-out deserializer with valid/ready output
module sipo_deser
  import shift_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in,
  input  logic                     in_valid,
  input  logic                     msb_first,
  input  logic                     clear,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         out,
  output logic                     out_valid,
  output logic [$clog2(WIDTH)-1:0] bit_cnt,
  output logic                     overrun
);

  logic [WIDTH-1:0] sr_q, sr_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic [WIDTH-1:0] shifted;
  logic             out_valid_q, out_valid_d;
  logic             overrun_q, overrun_d;
  bit_order_e       order_q, order_d;
  bit_order_e       eff_order;
  logic             take;
  logic             complete;

  // clear outranks a coincident serial bit, so the bit never reaches the counter
  assign take = in_valid && !clear;

  mod_counter #(
    .MOD (WIDTH)
  ) u_bit_counter (
    .clk   (clk),
    .rst_n (rst),
    .inc   (take),
    .clr   (clear),
    .count (bit_cnt),
    .wrap  (complete)
  );

  // the order input only matters on the first bit; later bits use the latched copy
  assign eff_order = (bit_cnt == '0) ? bit_order_e'(msb_first) : order_q;
  assign shifted   = (eff_order == MSB_FIRST) ? {sr_q[WIDTH-2:0], in}
                                              : {in, sr_q[WIDTH-1:1]};

  always_comb begin
    sr_d        = sr_q;
    order_d     = order_q;
    out_d       = out_q;
    out_valid_d = out_valid_q;
    overrun_d   = overrun_q;

    if (clear) begin
      sr_d      = '0;
      overrun_d = 1'b0;
    end else if (in_valid) begin
      sr_d    = shifted;
      order_d = eff_order;
    end

    if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end

    // a completed word lands only if the output slot is empty or draining this cycle
    if (complete) begin
      if (!out_valid_q || out_ready) begin
        out_d       = shifted;
        out_valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sr_q        <= '0;
      order_q     <= LSB_FIRST;
      out_q       <= '0;
      out_valid_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      sr_q        <= sr_d;
      order_q     <= order_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
      overrun_q   <= overrun_d;
    end
  end

  assign out       = out_q;
  assign out_valid = out_valid_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_sipo_deser.sv
// tb/tb_sipo_deser.sv - directed self-checking bench for sipo_deser at WIDTH=4
module tb_sipo_deser;

  localparam int W = 4;

  logic                   clk;
  logic                   rst;
  logic                   ser_in;
  logic                   in_valid;
  logic                   msb_first;
  logic                   clear;
  logic                   out_ready;
  logic [W-1:0]           out;
  logic                   out_valid;
  logic [$clog2(W)-1:0]   bit_cnt;
  logic                   overrun;

  int errors = 0;
  int checks = 0;

  sipo_deser #(
    .WIDTH (W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in        (ser_in),
    .in_valid  (in_valid),
    .msb_first (msb_first),
    .clear     (clear),
    .out_ready (out_ready),
    .out       (out),
    .out_valid (out_valid),
    .bit_cnt   (bit_cnt),
    .overrun   (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic expect_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic send_bit(input logic b);
    ser_in   = b;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_lsb_word(input logic [3:0] w);
    logic [3:0] v;
    v = w;
    for (int i = 0; i < 4; i++) send_bit(v[i]);
  endtask

  initial begin
    rst       = 1'b0;
    ser_in    = 1'b0;
    in_valid  = 1'b0;
    msb_first = 1'b0;
    clear     = 1'b0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    expect_eq("reset_out", out, 0);
    expect_eq("reset_out_valid", out_valid, 0);
    expect_eq("reset_bit_cnt", bit_cnt, 0);
    expect_eq("reset_overrun", overrun, 0);
    rst = 1'b1;

    // LSB-first 1,0,1,1 back-to-back
    out_ready = 1'b1;
    send_bit(1'b1);
    expect_eq("lsb_cnt1", bit_cnt, 1);
    send_bit(1'b0);
    expect_eq("lsb_cnt2", bit_cnt, 2);
    send_bit(1'b1);
    expect_eq("lsb_cnt3", bit_cnt, 3);
    expect_eq("lsb_no_early_valid", out_valid, 0);
    send_bit(1'b1);
    expect_eq("lsb_out", out, 4'b1101);
    expect_eq("lsb_out_valid", out_valid, 1);
    expect_eq("lsb_cnt_wrap", bit_cnt, 0);
    idle(1);
    expect_eq("lsb_valid_drop", out_valid, 0);
    expect_eq("lsb_out_hold", out, 4'b1101);

    // MSB-first with gaps; order input toggled after the first bit
    msb_first = 1'b1;
    send_bit(1'b1);
    msb_first = 1'b0;
    idle(3);
    expect_eq("gap_cnt_hold", bit_cnt, 1);
    send_bit(1'b0);
    idle(3);
    send_bit(1'b1);
    idle(3);
    expect_eq("gap_cnt3", bit_cnt, 3);
    send_bit(1'b1);
    expect_eq("msb_out", out, 4'b1011);
    expect_eq("msb_out_valid", out_valid, 1);
    idle(1);
    expect_eq("msb_valid_drop", out_valid, 0);

    // back-to-back frames with consumer stalled
    out_ready = 1'b0;
    send_lsb_word(4'b1111);
    expect_eq("stall_first_out", out, 4'b1111);
    expect_eq("stall_first_overrun", overrun, 0);
    send_lsb_word(4'b0001);
    expect_eq("stall_out_kept", out, 4'b1111);
    expect_eq("stall_overrun", overrun, 1);
    expect_eq("stall_valid", out_valid, 1);
    idle(2);
    expect_eq("overrun_sticky", overrun, 1);
    clear = 1'b1;
    idle(1);
    clear = 1'b0;
    expect_eq("clear_overrun", overrun, 0);
    expect_eq("clear_keeps_valid", out_valid, 1);
    expect_eq("clear_keeps_out", out, 4'b1111);
    out_ready = 1'b1;
    idle(1);
    expect_eq("drain_valid", out_valid, 0);

    // clear coincident with a third bit, then a fresh frame
    send_bit(1'b1);
    send_bit(1'b1);
    clear = 1'b1;
    send_bit(1'b1);
    clear = 1'b0;
    expect_eq("clear_cnt", bit_cnt, 0);
    expect_eq("clear_no_valid", out_valid, 0);
    send_lsb_word(4'b0110);
    expect_eq("post_clear_out", out, 4'b0110);
    expect_eq("post_clear_valid", out_valid, 1);
    idle(1);

    // asynchronous reset mid-frame
    send_bit(1'b1);
    send_bit(1'b1);
    send_bit(1'b1);
    #3;
    rst = 1'b0;
    #1;
    expect_eq("arst_out", out, 0);
    expect_eq("arst_valid", out_valid, 0);
    expect_eq("arst_cnt", bit_cnt, 0);
    expect_eq("arst_overrun", overrun, 0);
    @(posedge clk);
    #1;
    expect_eq("arst_hold_cnt", bit_cnt, 0);
    rst = 1'b1;
    send_lsb_word(4'b0010);
    expect_eq("post_rst_out", out, 4'b0010);
    expect_eq("post_rst_valid", out_valid, 1);
    idle(1);

    // completion in the same cycle the previous word is accepted
    out_ready = 1'b0;
    send_lsb_word(4'b0001);
    expect_eq("reload_first", out, 4'b0001);
    send_bit(1'b1);
    send_bit(1'b1);
    send_bit(1'b0);
    out_ready = 1'b1;
    send_bit(1'b1);
    expect_eq("reload_out", out, 4'b1011);
    expect_eq("reload_valid", out_valid, 1);
    expect_eq("reload_overrun", overrun, 0);
    idle(1);
    expect_eq("reload_drain", out_valid, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sipo_deser.md
SIPO_DESER -- requirements
Module: sipo_deser

Interface
REQ-001 The module SHALL take parameter WIDTH, default 8, setting the parallel word width in bits; legal range 2..64.
REQ-002 The module SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 The module SHALL have port rst, input, 1, asynchronous active-low reset.
REQ-004 The module SHALL have port in, input, 1, serial data bit.
REQ-005 The module SHALL have port in_valid, input, 1, qualifying `in`; a bit is consumed only on cycles with in_valid=1.
REQ-006 The module SHALL have port msb_first, input, 1, bit-order select: 0 = LSB first, 1 = MSB first.
REQ-007 The module SHALL have port clear, input, 1, synchronous abort of the partial frame.
REQ-008 The module SHALL have port out_ready, input, 1, consumer accepts the word.
REQ-009 The module SHALL have port out, output, WIDTH, the assembled parallel word.
REQ-010 The module SHALL have port out_valid, output, 1, meaning `out` holds an unconsumed word.
REQ-011 The module SHALL have port bit_cnt, output, $clog2(WIDTH), the number of bits of the current partial frame.
REQ-012 The module SHALL have port overrun, output, 1, a sticky flag that a completed word was dropped.

Function
REQ-013 On each in_valid=1 cycle, the module SHALL shift in `in` and increment bit_cnt.
REQ-014 In LSB-first mode, the module SHALL shift right with the new bit entering at bit WIDTH-1, so the first received bit ends at bit 0.
REQ-015 In MSB-first mode, the module SHALL shift left with the new bit entering at bit 0, so the first received bit ends at bit WIDTH-1.
REQ-016 The module SHALL latch msb_first on the first bit of a frame (bit_cnt=0 and in_valid=1) and SHALL ignore changes to it until that frame completes or is cleared.
REQ-017 The module SHALL treat the in_valid cycle with bit_cnt=WIDTH-1 as frame completion: on the next cycle, out = assembled word, out_valid = 1, and bit_cnt = 0.
REQ-018 Latency from the last bit's sampling edge to out_valid SHALL be exactly 1 cycle.
REQ-019 The module SHALL allow in_valid gaps of any length, during which state holds; frames SHALL be back-to-back capable with no dead cycle.
REQ-020 When out_valid=1 and out_ready=1, the word SHALL transfer and out_valid SHALL fall on the next cycle, unless a frame completes in the same cycle, in which case out reloads and out_valid stays 1.
REQ-021 On completion with out_valid=1 and out_ready=0, the module SHALL discard the new word, leave out unchanged, and set overrun to 1.
REQ-022 overrun SHALL remain 1 until clear or reset.
REQ-023 out SHALL hold its value while out_valid=0 (no zeroing after transfer).
REQ-024 On clear=1, the module SHALL zero bit_cnt, the shift register, and overrun on the next edge; out and out_valid SHALL be unaffected.
REQ-025 When clear and in_valid are both 1 in the same cycle, clear SHALL win and the bit SHALL be dropped.
REQ-026 When clear coincides with a completing bit, the module SHALL drop the word and leave out_valid unchanged by it.

Reset
REQ-027 While rst=0, the module SHALL immediately force out=0, out_valid=0, bit_cnt=0, overrun=0, shift register=0, and latched order=0, independent of clk.
REQ-028 A reset asserted mid-frame SHALL discard the partial frame; the first in_valid bit after release SHALL start a new frame.

Structure
REQ-029 Shared package shift_pkg SHALL hold the bit-order constants (LSB_FIRST=0, MSB_FIRST=1) and the default WIDTH.
REQ-030 Bit counting SHALL be a sub-module mod_counter (parameter MOD=WIDTH, with inputs inc and clr and output wrap); the shift register and handshake logic SHALL reside in sipo_deser.

Verification (WIDTH=4)
REQ-031 LSB-first serial bits 1,0,1,1 on consecutive cycles with out_ready=1 -> out=4'b1101 and out_valid=1 for one cycle, 1 cycle after the 4th bit.
REQ-032 MSB-first serial bits 1,0,1,1 with 3-cycle in_valid gaps, and msb_first toggled mid-frame -> out=4'b1011; the toggle is ignored.
REQ-033 Two frames 1111 then 0001 (LSB-first) back-to-back with out_ready=0 -> out stays 4'b1111, overrun=1; a later clear -> overrun=0 and out_valid still 1.
REQ-034 Two bits, then clear coincident with a third bit, then bits 0,1,1,0 (LSB-first) -> bit_cnt=0 after clear; out=4'b0110.
REQ-035 rst=0 asserted between clock edges after 3 bits -> all outputs read 0 before the next edge; the next 4 bits produce a fresh word.
REQ-036 out_valid=1 with out_ready=1 in the cycle a new frame completes -> out_valid stays 1, out = new word, overrun=0.
